logic_op_sequencer: RTL
=======================

Name: logic_op_sequencer

Overview:
- Issuing side of the ALU logical-unit interface: accepts logical-operation requests over a valid/ready handshake and drives the logical unit's one-hot ctrl and operand inputs.
- Sequences composite operations (NAND, NOR, XOR, ANDN) as multiple single-cycle passes through the unit, keeping intermediates in internal temporaries.
- Returns the final result over a valid/ready response handshake.
- Sits in the datapath between the microcontrol decode and the ALU's logical unit.

Parameters:
- NBITS, 32, datapath word width (matches shared definitions).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_op  in  3  operation code (see Behaviour).
- req_a  in  NBITS  operand A.
- req_b  in  NBITS  operand B.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer takes the result.
- rsp_y  out  NBITS  result.
- lu_a  out  NBITS  logical-unit operand A.
- lu_b  out  NBITS  logical-unit operand B.
- lu_ctrl  out  3  logical-unit control: AND=001, OR=010, NOTB=100, NOP=000.
- lu_y  in  NBITS  logical-unit result (combinational from lu_a/lu_b/lu_ctrl).
- busy  out  1  high in EXEC or DONE.

Behaviour:
- Reset is asynchronous and active-high.
  - State goes to IDLE.
  - req_ready=1, rsp_valid=0, rsp_y=0, lu_a=0, lu_b=0, lu_ctrl=000, busy=0.
  - Latched operands, temporaries t1/t2 and the step counter clear to 0.
- Reset asserted mid-operation aborts it; no response is produced.
- FSM states: IDLE, EXEC, DONE.
- IDLE:
  - req_ready=1, lu_ctrl=000, lu_a=lu_b=0.
  - On req_valid at a clock edge: latch req_op, req_a, req_b; step=0; go to EXEC.
- EXEC:
  - req_ready=0.
  - lu_* are decoded from the registered op and step. They never depend on the req_* ports.
  - Each clock edge captures lu_y into the temporary named for that step and increments step.
  - On the last step, lu_y goes into rsp_y, rsp_valid is set and the FSM moves to DONE.
- DONE:
  - rsp_valid=1; rsp_y is held stable.
  - lu_ctrl=000, lu_a=lu_b=0.
  - On rsp_ready: rsp_valid=0, go to IDLE.
  - req_ready stays 0 in DONE. Back-to-back requests therefore have a one-cycle IDLE gap.
- Op table. Passes are listed as ctrl(lu_a, lu_b) -> destination. "x" denotes the latched A operand, distinct from the lu_a port.
  - 000 NOP: NOP(0,0) -> rsp_y. 1 pass, result 0.
  - 001 AND: AND(x,b) -> rsp_y. 1 pass.
  - 010 OR: OR(x,b) -> rsp_y. 1 pass.
  - 011 NOTB: NOTB(0,b) -> rsp_y. 1 pass.
  - 100 NAND: AND(x,b) -> t1; then NOTB(0,t1) -> rsp_y. 2 passes.
  - 101 NOR: OR(x,b) -> t1; then NOTB(0,t1) -> rsp_y. 2 passes.
  - 110 XOR: OR(x,b) -> t1; AND(x,b) -> t2; NOTB(0,t2) -> t2; AND(t1,t2) -> rsp_y. 4 passes.
  - 111 ANDN (a & ~b): NOTB(0,b) -> t1; then AND(x,t1) -> rsp_y. 2 passes.
- Latency: with the request accepted at edge E, rsp_valid rises at edge E+N (N = pass count) and is visible in the following cycle.
- Unused lu_a is driven 0 in NOTB and NOP passes.
- lu_ctrl is always one of the four legal codes.
- busy = (state != IDLE).
- Step counter is 2 bits. It cannot wrap past the op's final step, because reaching the final step always exits EXEC.
- rsp_valid held with rsp_ready low: stays in DONE indefinitely; rsp_y unchanged.
- req_valid while not in IDLE: ignored; the request is not latched.

Test Plan:
- Reset mid-XOR at pass 2 -> next cycle state IDLE, rsp_valid=0, lu_ctrl=000, req_ready=1; then NOP request -> rsp_y=0 after 1 pass.
- AND, OR, NOTB singly with req_a=0xF0F0_1234, req_b=0x0FF0_00FF, rsp_ready=1:
  - AND -> rsp_y=0x00F0_0034.
  - OR -> 0xFFF0_12FF.
  - NOTB -> 0xF00F_FF00.
  - Each rsp_valid arrives exactly 1 edge after acceptance; lu_ctrl=001/010/100 during EXEC.
- Same operands, XOR -> rsp_y=0xFF00_12CB.
  - rsp_valid after exactly 4 edges.
  - lu_ctrl sequence 010, 001, 100, 001.
  - req_ready=0 throughout.
- Same operands, NAND -> 0xFF0F_FFCB; NOR -> 0x000F_ED00; ANDN -> 0xF000_1200. Each takes 2 passes.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> rsp_y stable, busy=1, req_valid pulses ignored; rsp_ready=1 -> IDLE next cycle, then the next request is accepted.
- Random op/operand stream with random rsp_ready -> every rsp_y matches the reference op-table model; latency matches the pass count.

Source files
------------

// File: rtl/logic_op_sequencer.sv
// -----------------------------------------------------------------------------
// logic_op_sequencer
//
// Purpose:
//   Issuing side of the ALU logical-unit interface. The block accepts a
//   logical-operation request over a valid/ready handshake. It breaks composite
//   operations (NAND, NOR, XOR, ANDN) into single-cycle passes through an
//   external logical unit that only implements AND / OR / NOTB / NOP.
//   Intermediate values are kept in the temporaries t1/t2. The final value is
//   returned over a valid/ready response handshake.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-high reset
//   req_valid  in   request present
//   req_ready  out  block can accept a request (IDLE only)
//   req_op     in   [2:0] operation code
//   req_a      in   [NBITS-1:0] operand A
//   req_b      in   [NBITS-1:0] operand B
//   rsp_valid  out  result available (registered)
//   rsp_ready  in   consumer takes the result
//   rsp_y      out  [NBITS-1:0] result (registered, stable while rsp_valid)
//   lu_a       out  [NBITS-1:0] logical-unit operand A
//   lu_b       out  [NBITS-1:0] logical-unit operand B
//   lu_ctrl    out  [2:0] one-hot unit control: AND=001 OR=010 NOTB=100 NOP=000
//   lu_y       in   [NBITS-1:0] logical-unit result (combinational)
//   busy       out  high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module logic_op_sequencer #(
   parameter int NBITS = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [2:0]       req_op,
   input  logic [NBITS-1:0] req_a,
   input  logic [NBITS-1:0] req_b,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [NBITS-1:0] rsp_y,
   output logic [NBITS-1:0] lu_a,
   output logic [NBITS-1:0] lu_b,
   output logic [2:0]       lu_ctrl,
   input  logic [NBITS-1:0] lu_y,
   output logic             busy
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Logical-unit control codes
   localparam logic [2:0] CTRL_NOP  = 3'b000;
   localparam logic [2:0] CTRL_AND  = 3'b001;
   localparam logic [2:0] CTRL_OR   = 3'b010;
   localparam logic [2:0] CTRL_NOTB = 3'b100;

   // Operand sources for a pass ("x" is the latched A operand)
   localparam logic [2:0] SRC_ZERO = 3'd0;
   localparam logic [2:0] SRC_X    = 3'd1;
   localparam logic [2:0] SRC_B    = 3'd2;
   localparam logic [2:0] SRC_T1   = 3'd3;
   localparam logic [2:0] SRC_T2   = 3'd4;

   // Destination of a pass; DST_RSP marks the final pass of an op
   localparam logic [1:0] DST_T1  = 2'd0;
   localparam logic [1:0] DST_T2  = 2'd1;
   localparam logic [1:0] DST_RSP = 2'd2;

   typedef struct packed {
      logic [2:0] ctrl;
      logic [2:0] src_a;
      logic [2:0] src_b;
      logic [1:0] dst;
   } pass_t;

   // Microprogram: the pass executed for a given op at a given step.
   // Unreachable steps fall back to a NOP that finishes the op, so the
   // step counter can never run past an op's last pass.
   function automatic pass_t decode_pass(input logic [2:0] op, input logic [1:0] step);
      pass_t p;
      p.ctrl  = CTRL_NOP;
      p.src_a = SRC_ZERO;
      p.src_b = SRC_ZERO;
      p.dst   = DST_RSP;
      case (op)
         3'b000: begin
            p.ctrl = CTRL_NOP;
         end
         3'b001: begin
            p.ctrl = CTRL_AND;  p.src_a = SRC_X;  p.src_b = SRC_B;
         end
         3'b010: begin
            p.ctrl = CTRL_OR;   p.src_a = SRC_X;  p.src_b = SRC_B;
         end
         3'b011: begin
            p.ctrl = CTRL_NOTB; p.src_b = SRC_B;
         end
         3'b100, 3'b101: begin
            if (step == 2'd0) begin
               p.ctrl  = (op == 3'b100) ? CTRL_AND : CTRL_OR;
               p.src_a = SRC_X;
               p.src_b = SRC_B;
               p.dst   = DST_T1;
            end else begin
               p.ctrl  = CTRL_NOTB;
               p.src_b = SRC_T1;
            end
         end
         3'b110: begin
            // XOR = (x | b) & ~(x & b)
            case (step)
               2'd0: begin p.ctrl = CTRL_OR;   p.src_a = SRC_X;  p.src_b = SRC_B;  p.dst = DST_T1; end
               2'd1: begin p.ctrl = CTRL_AND;  p.src_a = SRC_X;  p.src_b = SRC_B;  p.dst = DST_T2; end
               2'd2: begin p.ctrl = CTRL_NOTB; p.src_b = SRC_T2; p.dst = DST_T2; end
               2'd3: begin p.ctrl = CTRL_AND;  p.src_a = SRC_T1; p.src_b = SRC_T2; end
               default: begin p.ctrl = CTRL_NOP; end
            endcase
         end
         3'b111: begin
            if (step == 2'd0) begin
               p.ctrl  = CTRL_NOTB;
               p.src_b = SRC_B;
               p.dst   = DST_T1;
            end else begin
               p.ctrl  = CTRL_AND;
               p.src_a = SRC_X;
               p.src_b = SRC_T1;
            end
         end
         default: begin
            p.ctrl = CTRL_NOP;
         end
      endcase
      return p;
   endfunction

   // Operand multiplexer shared by both lu ports
   function automatic logic [NBITS-1:0] sel_operand(
      input logic [2:0]       src,
      input logic [NBITS-1:0] x,
      input logic [NBITS-1:0] b,
      input logic [NBITS-1:0] t1,
      input logic [NBITS-1:0] t2
   );
      logic [NBITS-1:0] v;
      case (src)
         SRC_X:   v = x;
         SRC_B:   v = b;
         SRC_T1:  v = t1;
         SRC_T2:  v = t2;
         default: v = '0;
      endcase
      return v;
   endfunction

   state_t           state_q, state_d;
   logic [2:0]       op_q, op_d;
   logic [NBITS-1:0] x_q, x_d;
   logic [NBITS-1:0] b_q, b_d;
   logic [NBITS-1:0] t1_q, t1_d;
   logic [NBITS-1:0] t2_q, t2_d;
   logic [1:0]       step_q, step_d;
   logic [NBITS-1:0] rsp_y_q, rsp_y_d;
   logic             rsp_valid_q, rsp_valid_d;
   pass_t            pass_s;

   assign pass_s    = decode_pass(op_q, step_q);
   assign req_ready = (state_q == ST_IDLE);
   assign busy      = (state_q != ST_IDLE);
   assign rsp_valid = rsp_valid_q;
   assign rsp_y     = rsp_y_q;

   // Logical-unit drive. This depends only on registered state, so the
   // external combinational unit never sees the req_* ports.
   always_comb begin
      lu_ctrl = CTRL_NOP;
      lu_a    = '0;
      lu_b    = '0;
      if (state_q == ST_EXEC) begin
         lu_ctrl = pass_s.ctrl;
         lu_a    = sel_operand(pass_s.src_a, x_q, b_q, t1_q, t2_q);
         lu_b    = sel_operand(pass_s.src_b, x_q, b_q, t1_q, t2_q);
      end else begin
         lu_ctrl = CTRL_NOP;
      end
   end

   // Next-state logic: request latch, pass writeback and response handshake
   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      x_d         = x_q;
      b_d         = b_q;
      t1_d        = t1_q;
      t2_d        = t2_q;
      step_d      = step_q;
      rsp_y_d     = rsp_y_q;
      rsp_valid_d = rsp_valid_q;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               op_d    = req_op;
               x_d     = req_a;
               b_d     = req_b;
               step_d  = 2'd0;
               state_d = ST_EXEC;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_EXEC: begin
            case (pass_s.dst)
               DST_T1: begin
                  t1_d   = lu_y;
                  step_d = step_q + 2'd1;
               end
               DST_T2: begin
                  t2_d   = lu_y;
                  step_d = step_q + 2'd1;
               end
               DST_RSP: begin
                  rsp_y_d     = lu_y;
                  rsp_valid_d = 1'b1;
                  state_d     = ST_DONE;
               end
               default: begin
                  state_d = ST_IDLE;
               end
            endcase
         end
         ST_DONE: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end else begin
               rsp_valid_d = 1'b1;
            end
         end
         default: begin
            rsp_valid_d = 1'b0;
            state_d     = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         op_q        <= 3'd0;
         x_q         <= '0;
         b_q         <= '0;
         t1_q        <= '0;
         t2_q        <= '0;
         step_q      <= 2'd0;
         rsp_y_q     <= '0;
         rsp_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         x_q         <= x_d;
         b_q         <= b_d;
         t1_q        <= t1_d;
         t2_q        <= t2_d;
         step_q      <= step_d;
         rsp_y_q     <= rsp_y_d;
         rsp_valid_q <= rsp_valid_d;
      end
   end

endmodule
